mem_port_arbiter: RTL and testbench

Shares the single instruction/data memory port between the fetch stage and the memory (load/store) stage. It grants one requester at a time, latches its address, rw and access_size, drives the memory port until the memory acknowledges, then pulses a per-requester done. It generates the stall that holds the fetch pc, and the equivalent stall for the memory stage. Data accesses have priority. A streak limit prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/arb_priority_select.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter: FSM states,
// owner codes, rw polarity and the streak counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_F = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_FETCH = 2'b01;
    localparam logic [1:0] OWN_DATA  = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [31:0] WORD_SIZE = 32'd4;

    localparam int STREAK_W = 4;

    // The owner code is purely a function of which busy state we are in.
    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] own;
        own = OWN_NONE;
        case (st)
            ST_BUSY_F: own = OWN_FETCH;
            ST_BUSY_D: own = OWN_DATA;
            default:   own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Combinational grant pick between fetch and data, with the data-streak
// counter update that bounds how long fetch can be starved.
module arb_priority_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                f_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_f,
    output logic                grant_d,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    logic streak_full;

    assign streak_full = (streak >= STREAK_MAX);

    always_comb begin
        // Data wins unless fetch is waiting and data already used its streak.
        grant_d     = d_req & (~f_req | ~streak_full);
        grant_f     = f_req & ~grant_d;
        streak_next = streak;
        if (grant_f) begin
            streak_next = '0;
        end else if (grant_d) begin
            if (!f_req) begin
                streak_next = '0;
            end else begin
                // grant_d with f_req set implies streak < max, so no overflow.
                streak_next = streak + STREAK_ONE;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and the load/store stage: grants one
// requester, holds the latched access until mem_ack, then pulses its done.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [31:0]       f_access_size,
    output logic              f_stall,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_access_size,
    output logic              d_stall,
    output logic              d_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [31:0]       mem_access_size,
    input  logic              mem_ack,
    output logic [1:0]        owner
);

    arb_state_t          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rw_q, mem_rw_d;
    logic [31:0]         mem_size_q, mem_size_d;
    logic [1:0]          owner_q, owner_d;
    logic                f_done_q, f_done_d;
    logic                d_done_q, d_done_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                grant_f;
    logic                grant_d;
    logic [STREAK_W-1:0] streak_next;

    arb_priority_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_select (
        .f_req       (f_req),
        .d_req       (d_req),
        .streak      (streak_q),
        .grant_f     (grant_f),
        .grant_d     (grant_d),
        .streak_next (streak_next)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_rw_d   = mem_rw_q;
        mem_size_d = mem_size_q;
        streak_d   = streak_q;
        f_done_d   = 1'b0;
        d_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Arbitration only happens here; mem_ack while idle is ignored.
                streak_d = streak_next;
                if (grant_d) begin
                    state_d    = ST_BUSY_D;
                    mem_req_d  = 1'b1;
                    mem_addr_d = d_addr;
                    mem_rw_d   = d_rw;
                    mem_size_d = d_access_size;
                end else if (grant_f) begin
                    state_d    = ST_BUSY_F;
                    mem_req_d  = 1'b1;
                    mem_addr_d = f_addr;
                    mem_rw_d   = RW_READ;
                    mem_size_d = f_access_size;
                end
            end
            ST_BUSY_F, ST_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    f_done_d  = (state_q == ST_BUSY_F);
                    d_done_d  = (state_q == ST_BUSY_D);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        owner_d = owner_of(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_rw_q   <= RW_READ;
            mem_size_q <= '0;
            owner_q    <= OWN_NONE;
            f_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_rw_q   <= mem_rw_d;
            mem_size_q <= mem_size_d;
            owner_q    <= owner_d;
            f_done_q   <= f_done_d;
            d_done_q   <= d_done_d;
            streak_q   <= streak_d;
        end
    end

    // Stall drops in the done cycle so the requester advances exactly once.
    assign f_stall         = f_req & ~f_done_q;
    assign d_stall         = d_req & ~d_done_q;
    assign f_done          = f_done_q;
    assign d_done          = d_done_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign mem_rw          = mem_rw_q;
    assign mem_access_size = mem_size_q;
    assign owner           = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, contention,
// starvation guard, reset mid-access and spurious ack.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [31:0]   f_access_size;
    logic          f_stall;
    logic          f_done;
    logic          d_req;
    logic          d_rw;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_access_size;
    logic          d_stall;
    logic          d_done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [31:0]   mem_access_size;
    logic          mem_ack;
    logic [1:0]    owner;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .MAX_DATA_STREAK (4),
        .ADDR_W          (AW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .f_req           (f_req),
        .f_addr          (f_addr),
        .f_access_size   (f_access_size),
        .f_stall         (f_stall),
        .f_done          (f_done),
        .d_req           (d_req),
        .d_rw            (d_rw),
        .d_addr          (d_addr),
        .d_access_size   (d_access_size),
        .d_stall         (d_stall),
        .d_done          (d_done),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rw          (mem_rw),
        .mem_access_size (mem_access_size),
        .mem_ack         (mem_ack),
        .owner           (owner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Wait for a grant, check the latched access, ack after ack_delay cycles
    // and check the done cycle. Returns at the negedge of the done cycle.
    task automatic serve(input string tag, input int ack_delay, input logic [1:0] exp_owner,
                         input logic [31:0] exp_addr, input logic exp_rw, input logic [31:0] exp_size);
        bit   seen;
        logic is_f;
        seen = 1'b0;
        is_f = (exp_owner == OWN_FETCH);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_req) seen = 1'b1;
        end
        check_eq({tag, "_granted"}, 32'(seen), 32'd1);
        if (!seen) return;
        check_eq({tag, "_owner"}, 32'(owner), 32'(exp_owner));
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_rw"}, 32'(mem_rw), 32'(exp_rw));
        check_eq({tag, "_size"}, mem_access_size, exp_size);
        check_eq({tag, "_stall_busy"}, 32'(is_f ? f_stall : d_stall), 32'd1);
        for (int i = 1; i < ack_delay; i++) begin
            tick();
            check_eq({tag, "_hold_req"}, 32'(mem_req), 32'd1);
            check_eq({tag, "_hold_addr"}, mem_addr, exp_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq({tag, "_f_done"}, 32'(f_done), 32'(is_f));
        check_eq({tag, "_d_done"}, 32'(d_done), 32'(!is_f));
        check_eq({tag, "_req_low"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_owner_none"}, 32'(owner), 32'(OWN_NONE));
        check_eq({tag, "_stall_done"}, 32'(is_f ? f_stall : d_stall), 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0;
        f_req = 1'b1; f_addr = 32'h8002_0000; f_access_size = WORD_SIZE;
        d_req = 1'b0; d_rw = RW_READ; d_addr = '0; d_access_size = '0;

        // Reset held two cycles with fetch requesting
        tick(); tick();
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'(OWN_NONE));
        check_eq("rst_f_done", 32'(f_done), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_rw", 32'(mem_rw), 32'd1);
        check_eq("rst_mem_size", mem_access_size, 32'd0);
        check_eq("rst_f_stall", 32'(f_stall), 32'd1);
        reset = 1'b0;
        tick();
        check_eq("post_rst_grant", 32'(mem_req), 32'd1);
        check_eq("post_rst_owner", 32'(owner), 32'(OWN_FETCH));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("post_rst_done", 32'(f_done), 32'd1);
        f_req = 1'b0;
        tick();
        $display("reset: fetch granted on first edge after reset");

        // Fetch only, ack 3 cycles after mem_req
        f_req = 1'b1;
        serve("fetch", 3, OWN_FETCH, 32'h8002_0000, RW_READ, 32'd4);
        f_req = 1'b0;
        tick();
        check_eq("fetch_done_once", 32'(f_done), 32'd0);
        check_eq("fetch_no_regrant", 32'(mem_req), 32'd0);
        $display("fetch: addr 0x80020000 size 4 ack after 3 cycles");

        // Contention: data first, fetch once data drops
        f_req = 1'b1; f_addr = 32'h8002_0004;
        d_req = 1'b1; d_rw = RW_WRITE; d_addr = 32'h8002_0100; d_access_size = 32'd2;
        serve("cont_d", 1, OWN_DATA, 32'h8002_0100, RW_WRITE, 32'd2);
        check_eq("cont_f_stall", 32'(f_stall), 32'd1);
        d_req = 1'b0;
        serve("cont_f", 1, OWN_FETCH, 32'h8002_0004, RW_READ, 32'd4);
        f_req = 1'b0;
        tick();
        $display("contention: data write then fetch read");

        // Starvation guard: four data grants, then one fetch, then restart
        f_req = 1'b1; d_req = 1'b1; d_rw = RW_READ; d_addr = 32'h8002_0200; d_access_size = 32'd4;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                serve($sformatf("streak%0d_f", i), 1, OWN_FETCH, 32'h8002_0004, RW_READ, 32'd4);
            else
                serve($sformatf("streak%0d_d", i), 1, OWN_DATA, 32'h8002_0200, RW_READ, 32'd4);
            $display("streak: grant %0d owner %0d", i, (i == 4 || i == 9) ? 1 : 2);
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
        check_eq("streak_idle", 32'(mem_req), 32'd0);

        // Dropped request still completes; latched access ignores input changes
        d_req = 1'b1; d_rw = RW_WRITE; d_addr = 32'h8002_0300; d_access_size = 32'd1;
        tick();
        check_eq("drop_grant", 32'(owner), 32'(OWN_DATA));
        d_req = 1'b0; d_addr = 32'h1234_5678; d_rw = RW_READ;
        tick();
        check_eq("drop_addr_stable", mem_addr, 32'h8002_0300);
        check_eq("drop_rw_stable", 32'(mem_rw), 32'(RW_WRITE));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("drop_d_done", 32'(d_done), 32'd1);
        tick();
        $display("dropped request: d_done still pulsed");

        // Reset in the middle of a data access
        d_req = 1'b1; d_rw = RW_WRITE; d_addr = 32'h8002_0400; d_access_size = 32'd4;
        tick();
        check_eq("rstmid_busy", 32'(owner), 32'(OWN_DATA));
        reset = 1'b1;
        tick();
        check_eq("rstmid_req", 32'(mem_req), 32'd0);
        check_eq("rstmid_owner", 32'(owner), 32'(OWN_NONE));
        check_eq("rstmid_d_done", 32'(d_done), 32'd0);
        reset = 1'b0; d_req = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("rstmid_late_ack_done", 32'(d_done), 32'd0);
        check_eq("rstmid_late_ack_req", 32'(mem_req), 32'd0);
        $display("reset mid-access: access abandoned");

        // Spurious ack while idle
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("spur_owner", 32'(owner), 32'(OWN_NONE));
            check_eq("spur_req", 32'(mem_req), 32'd0);
            check_eq("spur_done", 32'({f_done, d_done}), 32'd0);
        end
        mem_ack = 1'b0;
        tick();
        $display("spurious ack: ignored in idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
